// File: rtl/disp_pkg.sv
// Shared constants for the stopwatch seven-segment display path.
// Segment encodings are active-low, bit order g..a.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index n holds the glyph for BCD digit n
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_e;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 are not valid BCD and show a dash.
module bcd_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_DIGITS[0];
      4'd1: seg = SEG_DIGITS[1];
      4'd2: seg = SEG_DIGITS[2];
      4'd3: seg = SEG_DIGITS[3];
      4'd4: seg = SEG_DIGITS[4];
      4'd5: seg = SEG_DIGITS[5];
      4'd6: seg = SEG_DIGITS[6];
      4'd7: seg = SEG_DIGITS[7];
      4'd8: seg = SEG_DIGITS[8];
      4'd9: seg = SEG_DIGITS[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_disp_mux.sv
// 3-digit time-multiplexed common-anode display driver with per-frame digit snapshot
// and inter-slot blanking. Define LEADING_ZERO_BLANK_EN for leading-zero suppression.
module stopwatch_disp_mux
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [2:0] dp_sel,
  output logic [2:0] an,
  output logic [6:0] sseg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]      cnt;
  logic [1:0]            slot;
  logic [3:0]            s0, s1, s2;
  logic [NUM_DIGITS-1:0] sdp;

  logic       snap;
  phase_e     phase;
  logic [3:0] cur_digit;
  logic       cur_dp;
  logic [6:0] cur_seg;
  logic       suppress;
  logic [2:0] an_nx;
  logic [6:0] sseg_nx;
  logic       dp_nx;

  always_comb begin
    snap  = (cnt == '0) && (slot == 2'd0);
    phase = (cnt < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
    case (slot)
      2'd1:    begin cur_digit = s1; cur_dp = sdp[1]; end
      2'd2:    begin cur_digit = s2; cur_dp = sdp[2]; end
      default: begin cur_digit = s0; cur_dp = sdp[0]; end
    endcase
  end

  bcd_to_sseg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    suppress = ((slot == 2'd2) && (s2 == 4'd0)) ||
               ((slot == 2'd1) && (s2 == 4'd0) && (s1 == 4'd0));
  end
`else
  always_comb begin
    suppress = 1'b0;
  end
`endif

  // A suppressed digit that carries a decimal point still lights its anode for the dp alone
  always_comb begin
    an_nx   = '1;
    sseg_nx = SEG_BLANK;
    dp_nx   = 1'b1;
    if (phase == PH_DRIVE) begin
      if (!suppress) begin
        an_nx   = ~(3'b001 << slot);
        sseg_nx = cur_seg;
        dp_nx   = ~cur_dp;
      end else if (cur_dp) begin
        an_nx   = ~(3'b001 << slot);
        sseg_nx = SEG_BLANK;
        dp_nx   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt         <= '0;
      slot        <= 2'd0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      sdp         <= '0;
      an          <= '1;
      sseg        <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (snap) begin
        s0  <= d0;
        s1  <= d1;
        s2  <= d2;
        sdp <= dp_sel;
      end
      frame_start <= snap;
      an          <= an_nx;
      sseg        <= sseg_nx;
      dp          <= dp_nx;
    end
  end

endmodule

// File: tb/tb_stopwatch_disp_mux.sv
// Directed bench for stopwatch_disp_mux at REFRESH_DIV=8, BLANK_CYCLES=2 (24-cycle frame).
// Expected glyphs per slot are hand-set; cycle position decides blank/drive and slot.
module tb_stopwatch_disp_mux;

  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] d0, d1, d2;
  logic [2:0] dp_sel;
  logic [2:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic       frame_start;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pos      = 0;

  logic [6:0] exp_seg [3];
  logic       exp_dp  [3];
  logic       exp_en  [3];

  stopwatch_disp_mux #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .dp_sel      (dp_sel),
    .an          (an),
    .sseg        (sseg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s pos=%0d: got %h expected %h", tag, pos, got, want);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"},   32'(an),          32'h7);
    check({tag, "_sseg"}, 32'(sseg),        32'h7f);
    check({tag, "_dp"},   32'(dp),          32'h1);
    check({tag, "_fs"},   32'(frame_start), 32'h0);
  endtask

  // One clock: sample after the edge, compare against the slot schedule for this position
  task automatic step();
    int unsigned fp, sl, c;
    logic [2:0] w_an;
    logic [6:0] w_seg;
    logic       w_dp;
    @(negedge clk);
    fp = pos % (3 * RD);
    sl = fp / RD;
    c  = fp % RD;
    w_an  = 3'b111;
    w_seg = 7'b1111111;
    w_dp  = 1'b1;
    if (c >= BC && exp_en[sl]) begin
      w_an        = 3'b111;
      w_an[sl]    = 1'b0;
      w_seg       = exp_seg[sl];
      w_dp        = exp_dp[sl];
    end
    check("an",   32'(an),          32'(w_an));
    check("sseg", 32'(sseg),        32'(w_seg));
    check("dp",   32'(dp),          32'(w_dp));
    check("fs",   32'(frame_start), 32'(fp == 0));
    pos++;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic set_exp(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                         input logic [2:0] dpl, input logic [2:0] en);
    exp_seg[0] = g0; exp_seg[1] = g1; exp_seg[2] = g2;
    exp_dp[0]  = dpl[0]; exp_dp[1] = dpl[1]; exp_dp[2] = dpl[2];
    exp_en[0]  = en[0];  exp_en[1] = en[1];  exp_en[2] = en[2];
  endtask

  task automatic release_clr();
    @(negedge clk);
    clr = 1'b0;
    pos = 0;
  endtask

  initial begin
    clr = 1'b1; d0 = 4'd8; d1 = 4'd8; d2 = 4'd8; dp_sel = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_blank("rst_hold");
    end

    // Basic scan 1,2,3
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3; dp_sel = 3'b000;
    set_exp(7'b0110000, 7'b0100100, 7'b1111001, 3'b111, 3'b111);
    release_clr();
    run(24);

    // Change inputs in slot 1 of frame 2; frame 2 still shows 1,2,3
    run(12);
    d0 = 4'd7; d1 = 4'd9;
    run(12);
    set_exp(7'b1111000, 7'b0010000, 7'b1111001, 3'b111, 3'b111);
    run(24);

    // Invalid tens digit with decimal point on digit 1
    d1 = 4'hC; dp_sel = 3'b010;
    set_exp(7'b1111000, 7'b0111111, 7'b1111001, 3'b101, 3'b111);
    run(24);

    // Async reset while slot 1 is driving
    run(12);
    #2 clr = 1'b1;
    #1 check_blank("rst_async_s1");
    release_clr();
    run(24);

    // Async reset while slot 2 is driving, then recovery from slot 0
    run(20);
    #2 clr = 1'b1;
    #1 check_blank("rst_async_s2");
    release_clr();
    run(24);

    // Leading zeros 0,0,5
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd5; dp_sel = 3'b000;
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'b0010010, 7'b1000000, 7'b1000000, 3'b111, 3'b001);
`else
    set_exp(7'b0010010, 7'b1000000, 7'b1000000, 3'b111, 3'b111);
`endif
    run(24);

    dp_sel = 3'b100;
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'b0010010, 7'b1000000, 7'b1111111, 3'b011, 3'b101);
`else
    set_exp(7'b0010010, 7'b1000000, 7'b1000000, 3'b011, 3'b111);
`endif
    run(24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
